irq_request_latch: RTL and testbench

IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

---
 rtl/irq_pkg.sv | 20 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/irq_request_latch.sv | 77 +++++++
 tb/tb_irq_request_latch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt request latch: source count, ack index
// width and the enable value loaded at reset.
package irq_pkg;

    localparam int NUM_SRC = 8;
    localparam int IDX_W   = 3;

    localparam logic [NUM_SRC-1:0] EN_RST_VAL = 8'hFF;

    typedef logic [NUM_SRC-1:0] src_vec_t;
    typedef logic [IDX_W-1:0]   src_idx_t;

    function automatic src_vec_t idx_to_onehot(input src_idx_t idx);
        src_vec_t v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// One request line: SYNC_STAGES-deep synchronizer, a history flop, and a
// rising-edge pulse that is high for one cycle per synchronized 0->1.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/irq_request_latch.sv
// Latches edge-detected interrupt requests into a pending vector, gated by an
// enable register, with per-source sticky overflow and acknowledge-error pulse.
module irq_request_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req_i,
    input  logic               mask_we_i,
    input  logic [NUM_SRC-1:0] mask_wdata_i,
    input  logic               ack_i,
    input  logic [IDX_W-1:0]   ack_idx_i,
    output logic [NUM_SRC-1:0] pend_o,
    output logic               irq_o,
    output logic [NUM_SRC-1:0] ovf_o,
    output logic               ack_err_o
);

    src_vec_t rise;
    src_vec_t pending_q, pending_d;
    src_vec_t enable_q;
    src_vec_t ovf_q, ovf_d;
    src_vec_t ack_hit;
    logic     ack_miss;
    logic     ack_err_q;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
        sync_edge_det #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (req_i[n]),
            .rise_o(rise[n])
        );
    end

    // A new edge always wins over an ack of the same source; the ack still
    // clears overflow because the old event has been serviced.
    always_comb begin
        ack_hit  = '0;
        ack_miss = 1'b0;
        if (ack_i) begin
            if (pending_q[ack_idx_i]) begin
                ack_hit = idx_to_onehot(ack_idx_i);
            end else begin
                ack_miss = 1'b1;
            end
        end
        pending_d = (pending_q & ~ack_hit) | rise;
        ovf_d     = (ovf_q | (rise & pending_q)) & ~ack_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
            enable_q  <= EN_RST_VAL;
            ack_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            ack_err_q <= ack_miss;
            if (mask_we_i) begin
                enable_q <= mask_wdata_i;
            end
        end
    end

    assign pend_o    = pending_q & enable_q;
    assign irq_o     = |pend_o;
    assign ovf_o     = ovf_q;
    assign ack_err_o = ack_err_q;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed bench for irq_request_latch: an event-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_irq_request_latch;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic       mask_we_i;
    logic [7:0] mask_wdata_i;
    logic       ack_i;
    logic [2:0] ack_idx_i;
    logic [7:0] pend_o;
    logic       irq_o;
    logic [7:0] ovf_o;
    logic       ack_err_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    irq_request_latch #(.SYNC_STAGES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .mask_we_i   (mask_we_i),
        .mask_wdata_i(mask_wdata_i),
        .ack_i       (ack_i),
        .ack_idx_i   (ack_idx_i),
        .pend_o      (pend_o),
        .irq_o       (irq_o),
        .ovf_o       (ovf_o),
        .ack_err_o   (ack_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. samp[k] holds the req_i value sampled k+1 edges ago;
    // an event on source n lands in pending S+1 edges after a 0->1 was sampled.
    logic [7:0] samp [0:3];
    bit   m_pend [8];
    bit   m_ovf  [8];
    bit   m_en   [8];
    bit   m_aerr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) samp[k] = 8'h00;
            for (int n = 0; n < 8; n++) begin
                m_pend[n] = 0;
                m_ovf[n]  = 0;
                m_en[n]   = 1;
            end
            m_aerr = 0;
        end else begin
            bit was_pending;
            m_aerr = ack_i && !m_pend[ack_idx_i];
            for (int n = 0; n < 8; n++) begin
                bit ev, acked;
                ev    = samp[S-1][n] && !samp[S][n];
                acked = ack_i && (int'(ack_idx_i) == n) && m_pend[n];
                was_pending = m_pend[n];
                if (acked) begin
                    m_ovf[n]  = 0;
                    m_pend[n] = ev;
                end else if (ev) begin
                    if (was_pending) m_ovf[n] = 1;
                    m_pend[n] = 1;
                end
                if (mask_we_i) m_en[n] = mask_wdata_i[n];
            end
            for (int k = 3; k > 0; k--) samp[k] = samp[k-1];
            samp[0] = req_i;
        end
    end

    function automatic logic [7:0] exp_pend();
        logic [7:0] v;
        for (int n = 0; n < 8; n++) v[n] = m_pend[n] && m_en[n];
        return v;
    endfunction

    function automatic logic [7:0] exp_ovf();
        logic [7:0] v;
        for (int n = 0; n < 8; n++) v[n] = m_ovf[n];
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        vec_cnt++;
        if (act !== expv) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h at t=%0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model.pend_o",    pend_o,             exp_pend());
        chk("model.irq_o",     {7'd0, irq_o},      {7'd0, |exp_pend()});
        chk("model.ovf_o",     ovf_o,              exp_ovf());
        chk("model.ack_err_o", {7'd0, ack_err_o},  {7'd0, m_aerr});
    end

    // Input changes land 1 time unit after the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] v, input int hi, input int lo);
        req_i = v;
        cyc(hi);
        req_i = 8'h00;
        cyc(lo);
    endtask

    task automatic ack(input logic [2:0] idx);
        ack_i = 1'b1;
        ack_idx_i = idx;
        cyc(1);
        ack_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_i = 8'h00;
        mask_we_i = 1'b0;
        mask_wdata_i = 8'h00;
        ack_i = 1'b0;
        ack_idx_i = 3'd0;
        cyc(3);
        chk("reset.pend_o", pend_o, 8'h00);
        chk("reset.ovf_o", ovf_o, 8'h00);
        chk("reset.irq_ackerr", {6'd0, irq_o, ack_err_o}, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        // Single event on bit 5: pend_o rises exactly 3 edges after sampling.
        req_i = 8'h20;
        cyc(2);
        chk("lat.pend_after2", pend_o, 8'h00);
        cyc(1);
        chk("lat.pend_after3", pend_o, 8'h20);
        chk("lat.irq", {7'd0, irq_o}, 8'h01);
        cyc(1);
        req_i = 8'h00;
        cyc(3);
        ack(3'd5);
        chk("ack5.pend", pend_o, 8'h00);
        chk("ack5.irq", {7'd0, irq_o}, 8'h00);
        cyc(2);

        // Masked events stay pending and reappear when re-enabled.
        mask_we_i = 1'b1;
        mask_wdata_i = 8'hF0;
        cyc(1);
        mask_we_i = 1'b0;
        req_i = 8'h03;
        cyc(5);
        chk("mask.pend", pend_o, 8'h00);
        chk("mask.irq", {7'd0, irq_o}, 8'h00);
        mask_we_i = 1'b1;
        mask_wdata_i = 8'hFF;
        cyc(1);
        mask_we_i = 1'b0;
        chk("unmask.pend", pend_o, 8'h03);
        req_i = 8'h00;
        ack(3'd0);
        ack(3'd1);
        cyc(3);

        // Overflow on bit 1.
        pulse(8'h02, 2, 2);
        pulse(8'h02, 2, 4);
        chk("ovf.set", ovf_o, 8'h02);
        ack(3'd1);
        chk("ovf.ack_pend", pend_o, 8'h00);
        chk("ovf.ack_ovf", ovf_o, 8'h00);
        cyc(2);

        // Bit 4: overflow first, then an ack coincident with a new event.
        pulse(8'h10, 2, 2);
        pulse(8'h10, 2, 4);
        chk("b4.ovf", ovf_o, 8'h10);
        req_i = 8'h10;
        cyc(2);
        ack(3'd4);
        chk("b4.coinc_pend", pend_o & 8'h10, 8'h10);
        chk("b4.coinc_ovf", ovf_o, 8'h00);
        req_i = 8'h00;
        cyc(2);
        ack(3'd4);
        cyc(1);

        // Ack of a non-pending source.
        ack(3'd6);
        chk("aerr.pulse", {7'd0, ack_err_o}, 8'h01);
        chk("aerr.pend", pend_o, 8'h00);
        cyc(1);
        chk("aerr.gone", {7'd0, ack_err_o}, 8'h00);
        cyc(2);

        // Simultaneous edges, mask write alongside ack, then reset mid-flight.
        pulse(8'hA5, 2, 2);
        pulse(8'h01, 2, 4);
        chk("pre_rst.pend", pend_o, 8'hA5);
        chk("pre_rst.ovf", ovf_o, 8'h01);
        req_i = 8'h80;
        rst_n = 1'b0;
        #1;
        chk("rst.pend", pend_o, 8'h00);
        chk("rst.ovf", ovf_o, 8'h00);
        chk("rst.irq", {7'd0, irq_o}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("rel.pend_after2", pend_o, 8'h00);
        cyc(1);
        chk("rel.pend_after3", pend_o, 8'h80);
        req_i = 8'h00;
        mask_we_i = 1'b1;
        mask_wdata_i = 8'h7F;
        ack(3'd7);
        mask_we_i = 1'b0;
        chk("mask_ack.pend", pend_o, 8'h00);
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
